action_sequencer: RTL and testbench
===================================

ACTION_SEQUENCER -- requirements
Module: action_sequencer

Interface
REQ-001 SHALL have parameter KICK_TOTAL, default 12: kick duration in frames.
REQ-002 SHALL have parameter GRAB_TOTAL, default 10: grab duration in frames.
REQ-003 SHALL have parameter WALK_TOTAL, default 16: walk cycle length in frames.
REQ-004 SHALL have parameter WIN_HOLD, default 31: saturation value of action_timer in WIN.
REQ-005 SHALL have port clk, input, 1: single clock; all logic in this domain.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port frame_tick, input, 1: one-cycle pulse, once per video frame.
REQ-008 SHALL have ports btn_fwd, btn_back, btn_kick, btn_grab, btn_block, input, 1 each: synchronised player buttons, level-sensitive.
REQ-009 SHALL have ports round_win, round_lose, input, 1 each: round result levels.
REQ-010 SHALL have port state, output, STATE_DEPTH: encodings from params.vh, fed to the sprite offset generator.
REQ-011 SHALL have port action_timer, output, SPRITE_INDEX_DEPTH: frame index within the current state.
REQ-012 SHALL have port hit_active, output, 1: attack hitbox live.
REQ-013 SHALL have port action_done, output, 1: one-cycle pulse when KICK or GRAB completes.

Function
REQ-014 SHALL register all outputs and change state/action_timer only in the cycle after a frame_tick.
REQ-015 SHALL capture a rising edge of btn_kick or btn_grab in a sticky press flag on any cycle, and clear the flag when it is consumed at a frame_tick.
REQ-016 SHALL evaluate transitions from NOTHING, WALK_FORWARD, WALK_BACKWARD and BLOCK at each tick with priority: round_win > round_lose > kick flag > grab flag > btn_block > btn_fwd > btn_back > NOTHING.
REQ-017 SHALL treat btn_fwd and btn_back asserted together as neither asserted.
REQ-018 SHALL set action_timer to 0 on every state change, and increment it on each tick while the state is unchanged.
REQ-019 SHALL hold KICK for KICK_TOTAL ticks and GRAB for GRAB_TOTAL ticks without interruption by any button; on the tick where the timer equals TOTAL-1, the next state SHALL be NOTHING and action_done SHALL pulse for one cycle.
REQ-020 SHALL wrap action_timer to 0 after WALK_TOTAL-1 while in WALK_FORWARD or WALK_BACKWARD.
REQ-021 SHALL keep action_timer at 0 in NOTHING, BLOCK and LOSE.
REQ-022 SHALL have round_win or round_lose override any state, including KICK and GRAB, at the next tick; round_win takes priority when both are set.
REQ-023 SHALL make WIN and LOSE terminal until reset, with the WIN timer saturating at WIN_HOLD.
REQ-024 SHALL assert hit_active only when (state==KICK and KICK_STARTUP < timer <= KICK_PULLBACK_FRAME) or (state==GRAB and GRAB_STARTUP < timer <= GRAB_PULLBACK_FRAME).
REQ-025 SHALL discard press flags captured during KICK or GRAB when the action completes, unless REQ-031 applies.
REQ-026 SHALL flag an elaboration error when KICK_PULLBACK_FRAME >= KICK_TOTAL or GRAB_PULLBACK_FRAME >= GRAB_TOTAL.
REQ-027 SHALL register a frame_tick that coincides with a button edge using the pre-edge button value, and set the flag for the next tick.

Reset
REQ-028 SHALL drive, while reset is low: state=NOTHING, action_timer=0, hit_active=0, action_done=0, all press flags cleared.
REQ-029 SHALL abort any KICK or GRAB in progress on reset, asynchronously, with no action_done pulse.
REQ-030 SHALL make the first tick after reset release evaluate from NOTHING.

Configuration
REQ-031 SHALL, with INPUT_BUFFER_EN defined, hold one buffered attack (latest press wins) captured during KICK or GRAB, and launch it at the completion tick: directly KICK/GRAB with timer 0 instead of NOTHING, with action_done still pulsing.
REQ-032 SHALL, without INPUT_BUFFER_EN defined, instantiate no buffer register and apply REQ-025.

Verification
REQ-033 SHALL verify: btn_kick edge, then 12 ticks -> state=KICK, timer 0..11, hit_active only in the window, then NOTHING and action_done for 1 cycle.
REQ-034 SHALL verify: btn_fwd held for 20 ticks -> WALK_FORWARD, timer 0..15, 0..3; release -> NOTHING at the next tick.
REQ-035 SHALL verify: btn_grab edge at timer 5 of KICK -> without INPUT_BUFFER_EN, NOTHING after the kick; with it, GRAB timer=0 after the kick.
REQ-036 SHALL verify: round_win asserted during KICK at timer 3 -> WIN next tick; timer saturates at 31 after 40 ticks; no action_done.
REQ-037 SHALL verify: reset low at KICK timer 6 -> outputs at reset values immediately; no pulse.
REQ-038 SHALL verify: btn_fwd=btn_back=1 and btn_block=1 -> BLOCK; drop block -> NOTHING.

Source files
------------

// File: rtl/action_sequencer_if.sv
// Player-input / sprite-state bundle between the game controller (master)
// and the fighter action sequencer (slave).
interface action_sequencer_if #(
    parameter int STATE_DEPTH        = 3,
    parameter int SPRITE_INDEX_DEPTH = 5
);
    logic                          frame_tick;
    logic                          btn_fwd;
    logic                          btn_back;
    logic                          btn_kick;
    logic                          btn_grab;
    logic                          btn_block;
    logic                          round_win;
    logic                          round_lose;
    logic [STATE_DEPTH-1:0]        state;
    logic [SPRITE_INDEX_DEPTH-1:0] action_timer;
    logic                          hit_active;
    logic                          action_done;

    modport master (
        output frame_tick, btn_fwd, btn_back, btn_kick, btn_grab, btn_block,
               round_win, round_lose,
        input  state, action_timer, hit_active, action_done
    );

    modport slave (
        input  frame_tick, btn_fwd, btn_back, btn_kick, btn_grab, btn_block,
               round_win, round_lose,
        output state, action_timer, hit_active, action_done
    );
endinterface

// File: rtl/action_sequencer.sv
// Frame-ticked fighter action FSM: walk/block/kick/grab/win/lose with sprite frame index.
// Optional INPUT_BUFFER_EN: buffers one attack pressed mid-action and chains it at completion.
module action_sequencer #(
    parameter int KICK_TOTAL          = 12,
    parameter int GRAB_TOTAL          = 10,
    parameter int WALK_TOTAL          = 16,
    parameter int WIN_HOLD            = 31,
    parameter int STATE_DEPTH         = 3,
    parameter int SPRITE_INDEX_DEPTH  = 5,
    parameter int KICK_STARTUP        = 3,
    parameter int KICK_PULLBACK_FRAME = 8,
    parameter int GRAB_STARTUP        = 2,
    parameter int GRAB_PULLBACK_FRAME = 6
) (
    input  logic              clk,
    input  logic              reset,
    action_sequencer_if.slave bus
);
    typedef logic [SPRITE_INDEX_DEPTH-1:0] timer_t;

    typedef enum logic [STATE_DEPTH-1:0] {
        ST_NOTHING       = STATE_DEPTH'(0),
        ST_WALK_FORWARD  = STATE_DEPTH'(1),
        ST_WALK_BACKWARD = STATE_DEPTH'(2),
        ST_BLOCK         = STATE_DEPTH'(3),
        ST_KICK          = STATE_DEPTH'(4),
        ST_GRAB          = STATE_DEPTH'(5),
        ST_WIN           = STATE_DEPTH'(6),
        ST_LOSE          = STATE_DEPTH'(7)
    } state_t;

    localparam timer_t KICK_LAST = timer_t'(KICK_TOTAL - 1);
    localparam timer_t GRAB_LAST = timer_t'(GRAB_TOTAL - 1);
    localparam timer_t WALK_LAST = timer_t'(WALK_TOTAL - 1);
    localparam timer_t WIN_MAX   = timer_t'(WIN_HOLD);
    localparam timer_t KICK_LO   = timer_t'(KICK_STARTUP);
    localparam timer_t KICK_HI   = timer_t'(KICK_PULLBACK_FRAME);
    localparam timer_t GRAB_LO   = timer_t'(GRAB_STARTUP);
    localparam timer_t GRAB_HI   = timer_t'(GRAB_PULLBACK_FRAME);

    generate
        if (KICK_PULLBACK_FRAME >= KICK_TOTAL || GRAB_PULLBACK_FRAME >= GRAB_TOTAL) begin : g_bad_pullback
            $error("action_sequencer: pullback frame must lie inside its action duration");
        end
        if (STATE_DEPTH < 3) begin : g_bad_state_depth
            $error("action_sequencer: STATE_DEPTH too small for eight states");
        end
        if (KICK_TOTAL < 1 || GRAB_TOTAL < 1 || WALK_TOTAL < 1) begin : g_bad_total
            $error("action_sequencer: action durations must be at least one frame");
        end
        if (KICK_TOTAL > 2**SPRITE_INDEX_DEPTH || GRAB_TOTAL > 2**SPRITE_INDEX_DEPTH ||
            WALK_TOTAL > 2**SPRITE_INDEX_DEPTH || WIN_HOLD >= 2**SPRITE_INDEX_DEPTH) begin : g_bad_timer_width
            $error("action_sequencer: SPRITE_INDEX_DEPTH too narrow for configured durations");
        end
    endgenerate

    state_t state_q, state_d;
    timer_t timer_q, timer_d;
    logic   hit_q, hit_d;
    logic   done_q, done_d;
    logic   kick_prev_q, kick_prev_d;
    logic   grab_prev_q, grab_prev_d;
    logic   kick_flag_q, kick_flag_d;
    logic   grab_flag_q, grab_flag_d;

    logic   kick_edge, grab_edge;
    logic   attacking, attack_last, restart;
    logic   launch_valid, launch_grab;

    // A tick consumes the flags it sees; an edge in the same cycle lands in the flag for the next tick.
    always_comb begin
        kick_prev_d = bus.btn_kick;
        grab_prev_d = bus.btn_grab;
        kick_edge   = bus.btn_kick & ~kick_prev_q;
        grab_edge   = bus.btn_grab & ~grab_prev_q;
        kick_flag_d = bus.frame_tick ? kick_edge : (kick_flag_q | kick_edge);
        grab_flag_d = bus.frame_tick ? grab_edge : (grab_flag_q | grab_edge);
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        done_d      = 1'b0;
        restart     = 1'b0;
        attacking   = (state_q == ST_KICK) || (state_q == ST_GRAB);
        attack_last = ((state_q == ST_KICK) && (timer_q == KICK_LAST)) ||
                      ((state_q == ST_GRAB) && (timer_q == GRAB_LAST));

        if (bus.frame_tick) begin
            if (state_q == ST_WIN || state_q == ST_LOSE) begin
                state_d = state_q;
            end else if (bus.round_win) begin
                state_d = ST_WIN;
            end else if (bus.round_lose) begin
                state_d = ST_LOSE;
            end else if (attacking) begin
                if (attack_last) begin
                    done_d  = 1'b1;
                    restart = 1'b1;
                    if (launch_valid) begin
                        state_d = launch_grab ? ST_GRAB : ST_KICK;
                    end else begin
                        state_d = ST_NOTHING;
                    end
                end
            end else if (kick_flag_q) begin
                state_d = ST_KICK;
            end else if (grab_flag_q) begin
                state_d = ST_GRAB;
            end else if (bus.btn_block) begin
                state_d = ST_BLOCK;
            end else if (bus.btn_fwd && !bus.btn_back) begin
                state_d = ST_WALK_FORWARD;
            end else if (bus.btn_back && !bus.btn_fwd) begin
                state_d = ST_WALK_BACKWARD;
            end else begin
                state_d = ST_NOTHING;
            end

            // restart covers a chained attack re-entering the same state at frame 0
            if (restart || (state_d != state_q)) begin
                timer_d = '0;
            end else begin
                case (state_q)
                    ST_WALK_FORWARD,
                    ST_WALK_BACKWARD: timer_d = (timer_q == WALK_LAST) ? '0 : timer_q + 1'b1;
                    ST_KICK,
                    ST_GRAB:          timer_d = timer_q + 1'b1;
                    ST_WIN:           timer_d = (timer_q >= WIN_MAX) ? WIN_MAX : timer_q + 1'b1;
                    default:          timer_d = '0;
                endcase
            end
        end

        hit_d = ((state_d == ST_KICK) && (timer_d > KICK_LO) && (timer_d <= KICK_HI)) ||
                ((state_d == ST_GRAB) && (timer_d > GRAB_LO) && (timer_d <= GRAB_HI));
    end

`ifdef INPUT_BUFFER_EN
    logic buf_valid_q, buf_valid_d;
    logic buf_grab_q, buf_grab_d;

    // Latest press wins; the slot empties whenever the running attack ends for any reason.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_grab_d  = buf_grab_q;
        if (bus.frame_tick && attacking && (restart || (state_d != state_q))) begin
            buf_valid_d = 1'b0;
            buf_grab_d  = 1'b0;
        end else if (attacking && kick_edge) begin
            buf_valid_d = 1'b1;
            buf_grab_d  = 1'b0;
        end else if (attacking && grab_edge) begin
            buf_valid_d = 1'b1;
            buf_grab_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid_q <= 1'b0;
            buf_grab_q  <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_grab_q  <= buf_grab_d;
        end
    end

    assign launch_valid = buf_valid_q;
    assign launch_grab  = buf_grab_q;
`else
    assign launch_valid = 1'b0;
    assign launch_grab  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_NOTHING;
            timer_q     <= '0;
            hit_q       <= 1'b0;
            done_q      <= 1'b0;
            kick_prev_q <= 1'b0;
            grab_prev_q <= 1'b0;
            kick_flag_q <= 1'b0;
            grab_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            hit_q       <= hit_d;
            done_q      <= done_d;
            kick_prev_q <= kick_prev_d;
            grab_prev_q <= grab_prev_d;
            kick_flag_q <= kick_flag_d;
            grab_flag_q <= grab_flag_d;
        end
    end

    assign bus.state        = state_q;
    assign bus.action_timer = timer_q;
    assign bus.hit_active   = hit_q;
    assign bus.action_done  = done_q;
endmodule

// File: tb/tb_action_sequencer.sv
// Directed bench for action_sequencer: vector table for walk/block/attack flow,
// hand-written sequences for round results, async reset, coincident edges and buffering.
`timescale 1ns/1ps
module tb_action_sequencer;
    localparam logic [2:0] S_NOTHING = 3'd0;
    localparam logic [2:0] S_WF      = 3'd1;
    localparam logic [2:0] S_WB      = 3'd2;
    localparam logic [2:0] S_BLOCK   = 3'd3;
    localparam logic [2:0] S_KICK    = 3'd4;
    localparam logic [2:0] S_GRAB    = 3'd5;
    localparam logic [2:0] S_WIN     = 3'd6;
    localparam logic [2:0] S_LOSE    = 3'd7;

    typedef struct {
        logic       fwd, back, kick, grab, block;
        logic [2:0] st;
        logic [4:0] tm;
        logic       hit, done;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    logic clk;
    logic reset;

    action_sequencer_if #(.STATE_DEPTH(3), .SPRITE_INDEX_DEPTH(5)) bus ();

    action_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic f, input logic b, input logic k, input logic g,
                                input logic bl, input logic [2:0] st, input int tm,
                                input logic hit, input logic done);
        vec_t v;
        v.fwd = f; v.back = b; v.kick = k; v.grab = g; v.block = bl;
        v.st = st; v.tm = 5'(tm); v.hit = hit; v.done = done;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [2:0] st, input int tm,
                         input logic hit, input logic done);
        checks++;
        if (bus.state !== st || bus.action_timer !== 5'(tm) ||
            bus.hit_active !== hit || bus.action_done !== done) begin
            errors++;
            $display("FAIL %s: got state=%0d timer=%0d hit=%b done=%b, want state=%0d timer=%0d hit=%b done=%b",
                     name, bus.state, bus.action_timer, bus.hit_active, bus.action_done,
                     st, tm, hit, done);
        end else begin
            $display("ok   %s: state=%0d timer=%0d hit=%b done=%b",
                     name, bus.state, bus.action_timer, bus.hit_active, bus.action_done);
        end
    endtask

    task automatic set_inputs(input logic f, input logic b, input logic k, input logic g,
                              input logic bl, input logic w, input logic l);
        bus.btn_fwd    = f;
        bus.btn_back   = b;
        bus.btn_kick   = k;
        bus.btn_grab   = g;
        bus.btn_block  = bl;
        bus.round_win  = w;
        bus.round_lose = l;
    endtask

    // Called at a falling edge: inputs settle for one clock, then one frame tick.
    task automatic step(input logic f, input logic b, input logic k, input logic g,
                        input logic bl, input logic w, input logic l);
        set_inputs(f, b, k, g, bl, w, l);
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.frame_tick = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        bus.frame_tick = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0, 0);

        // kick: 12 frames, hitbox on frames 4..8, then NOTHING with a done pulse
        add(0, 0, 1, 0, 0, S_KICK, 0, 0, 0);
        for (int t = 1; t < 12; t++) add(0, 0, 0, 0, 0, S_KICK, t, (t > 3 && t <= 8), 0);
        add(0, 0, 0, 0, 0, S_NOTHING, 0, 0, 1);
        add(0, 0, 0, 0, 0, S_NOTHING, 0, 0, 0);
        // forward walk wraps at 16, release returns to NOTHING
        for (int i = 0; i < 20; i++) add(1, 0, 0, 0, 0, S_WF, i % 16, 0, 0);
        add(0, 0, 0, 0, 0, S_NOTHING, 0, 0, 0);
        add(0, 1, 0, 0, 0, S_WB, 0, 0, 0);
        add(0, 1, 0, 0, 0, S_WB, 1, 0, 0);
        add(1, 1, 0, 0, 0, S_NOTHING, 0, 0, 0);
        add(1, 1, 0, 0, 1, S_BLOCK, 0, 0, 0);
        add(1, 1, 0, 0, 1, S_BLOCK, 0, 0, 0);
        add(0, 0, 0, 0, 0, S_NOTHING, 0, 0, 0);
        add(1, 0, 0, 0, 1, S_BLOCK, 0, 0, 0);
        add(1, 0, 0, 0, 0, S_WF, 0, 0, 0);
        add(1, 0, 0, 0, 0, S_WF, 1, 0, 0);
        // kick beats block/fwd and cannot be interrupted; completion goes to NOTHING first
        add(1, 0, 1, 0, 1, S_KICK, 0, 0, 0);
        for (int t = 1; t < 12; t++) add(1, 0, 0, 0, 1, S_KICK, t, (t > 3 && t <= 8), 0);
        add(1, 0, 0, 0, 1, S_NOTHING, 0, 0, 1);
        add(1, 0, 0, 0, 1, S_BLOCK, 0, 0, 0);
        // grab: 10 frames, hitbox on frames 3..6
        add(0, 0, 0, 1, 0, S_GRAB, 0, 0, 0);
        for (int t = 1; t < 10; t++) add(0, 0, 0, 0, 0, S_GRAB, t, (t > 2 && t <= 6), 0);
        add(0, 0, 0, 0, 0, S_NOTHING, 0, 0, 1);
        add(0, 0, 0, 0, 0, S_NOTHING, 0, 0, 0);

        repeat (2) @(negedge clk);
        check("reset_state", S_NOTHING, 0, 0, 0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].fwd, vecs[i].back, vecs[i].kick, vecs[i].grab, vecs[i].block, 0, 0);
            check($sformatf("vec%0d", i), vecs[i].st, int'(vecs[i].tm), vecs[i].hit, vecs[i].done);
        end

        // grab pressed at kick frame 5
        do_reset();
        step(0, 0, 1, 0, 0, 0, 0);
        for (int t = 1; t <= 5; t++) step(0, 0, 0, 0, 0, 0, 0);
        check("buf_kick_t5", S_KICK, 5, 1, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        for (int t = 7; t <= 11; t++) step(0, 0, 0, 0, 0, 0, 0);
        check("buf_kick_t11", S_KICK, 11, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
`ifdef INPUT_BUFFER_EN
        check("buf_complete", S_GRAB, 0, 0, 1);
        @(negedge clk);
        check("done_one_cycle", S_GRAB, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("buf_after", S_GRAB, 1, 0, 0);
`else
        check("buf_complete", S_NOTHING, 0, 0, 1);
        @(negedge clk);
        check("done_one_cycle", S_NOTHING, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("buf_after", S_NOTHING, 0, 0, 0);
`endif

        // round_win overrides kick at frame 3; WIN saturates at 31
        do_reset();
        step(0, 0, 1, 0, 0, 0, 0);
        for (int t = 1; t <= 3; t++) step(0, 0, 0, 0, 0, 0, 0);
        check("win_kick_t3", S_KICK, 3, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("win_enter", S_WIN, 0, 0, 0);
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, i[0], 0, 0, 0, (i == 20));
            check($sformatf("win_tick%0d", i), S_WIN, (i < 31) ? i : 31, 0, 0);
        end

        // async reset mid-kick: outputs clear without waiting for a clock
        do_reset();
        step(0, 0, 1, 0, 0, 0, 0);
        for (int t = 1; t <= 6; t++) step(0, 0, 0, 0, 0, 0, 0);
        check("rst_kick_t6", S_KICK, 6, 1, 0);
        #2 reset = 1'b0;
        #1 check("rst_async", S_NOTHING, 0, 0, 0);
        @(negedge clk);
        bus.btn_kick = 1'b1;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.btn_kick = 1'b0;
        bus.frame_tick = 1'b0;
        @(negedge clk);
        check("rst_hold", S_NOTHING, 0, 0, 0);
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        check("rst_release", S_NOTHING, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        check("rst_new_kick", S_KICK, 0, 0, 0);

        // win and lose together: win wins
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        check("both_walk", S_WF, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 1);
        check("both_win", S_WIN, 0, 0, 0);

        // LOSE is terminal with timer held at 0
        do_reset();
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("lose_grab_t1", S_GRAB, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        check("lose_enter", S_LOSE, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0);
        check("lose_hold_kick", S_LOSE, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        check("lose_hold_win", S_LOSE, 0, 0, 0);

        // kick edge coinciding with a tick is seen on the following tick
        do_reset();
        bus.btn_kick = 1'b1;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        check("coincide_tick", S_NOTHING, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        check("coincide_next", S_KICK, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
